// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types for the memory-access stage.
// FSM state and address-region enums, the address decoder, wait-counter width.
package mem_stage_pkg;

  localparam int CNT_W = 4;
  localparam int CH_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    R_RAM      = 2'd0,
    R_IO_OUT   = 2'd1,
    R_IO_IN    = 2'd2,
    R_UNMAPPED = 2'd3
  } region_e;

  typedef struct packed {
    region_e         region;
    logic [CH_W-1:0] chan;
  } dec_t;

  // Classify a word address. Even offsets in the I/O window are output
  // registers, odd offsets are the matching input channel.
  function automatic dec_t decode_addr(input logic [31:0] addr,
                                       input logic [31:0] mem_depth,
                                       input logic [31:0] io_base,
                                       input logic [31:0] num_io);
    dec_t        res;
    logic [31:0] off;
    res.region = R_UNMAPPED;
    res.chan   = {CH_W{1'b0}};
    off        = addr - io_base;
    if (addr < mem_depth) begin
      res.region = R_RAM;
    end else if ((addr >= io_base) && (off < (num_io << 1))) begin
      res.chan   = CH_W'(off >> 1);
      res.region = off[0] ? R_IO_IN : R_IO_OUT;
    end else begin
      res.region = R_UNMAPPED;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_stage_sync.sv
// mem_stage_sync: parametrised-width two-flop synchronizer, reset to zero.
module mem_stage_sync #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] ff1_q;
  logic [W-1:0] ff2_q;

  // Two-stage capture of the asynchronous input bus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ff1_q <= {W{1'b0}};
      ff2_q <= {W{1'b0}};
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/mem_stage_mmio.sv
// mem_stage_mmio: multicycle memory-access stage with word RAM, MDR and an
// MMIO window of NUM_IO output/input channel pairs, req/busy/done handshake.
// Optional input synchronizers enabled by defining MEM_STAGE_IO_SYNC_EN.
module mem_stage_mmio
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int MEM_DEPTH   = 1024,
  parameter int NUM_IO      = 2,
  parameter int IO_BASE     = 'h3FF0,
  parameter int WAIT_STATES = 1
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     we,
  input  logic                     mdrw,
  input  logic [ADDR_W-1:0]        addr_in,
  input  logic [DATA_W-1:0]        dataw_in,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [DATA_W-1:0]        mem_out,
  output logic [DATA_W-1:0]        mdr_out,
  input  logic [NUM_IO*DATA_W-1:0] dp_input,
  output logic [NUM_IO*DATA_W-1:0] dp_out
);

  localparam int RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int IO_W   = NUM_IO * DATA_W;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               we_q;
  logic               mdrw_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [DATA_W-1:0]  mem_out_q;
  logic [DATA_W-1:0]  mdr_q;
  logic [IO_W-1:0]    dp_out_q;
  logic [DATA_W-1:0]  ram_q [MEM_DEPTH];

  dec_t               dec_d;
  logic               exec_d;
  logic [DATA_W-1:0]  rd_val_d;
  logic               acc_err_d;
  logic [IO_W-1:0]    io_in_d;

  // Decode the captured address, not the live bus, so the master may change
  // addr_in while the access is in flight.
  assign dec_d  = decode_addr(32'(addr_q), 32'(MEM_DEPTH), 32'(IO_BASE), 32'(NUM_IO));
  assign exec_d = (state_q == S_ACCESS) && (cnt_q == {CNT_W{1'b0}});

`ifdef MEM_STAGE_IO_SYNC_EN
  for (genvar g = 0; g < NUM_IO; g++) begin : g_sync
    mem_stage_sync #(.W(DATA_W)) u_sync (
      .clk_i (CLK),
      .rst_i (reset),
      .d_i   (dp_input[g*DATA_W +: DATA_W]),
      .q_o   (io_in_d[g*DATA_W +: DATA_W])
    );
  end
`else
  assign io_in_d = dp_input;
`endif

  // Read data and error classification for the access at the execution edge.
  always_comb begin
    rd_val_d  = {DATA_W{1'b0}};
    acc_err_d = 1'b0;
    case (dec_d.region)
      R_RAM: begin
        rd_val_d = ram_q[addr_q[RAM_AW-1:0]];
      end
      R_IO_OUT: begin
        rd_val_d = dp_out_q[int'(dec_d.chan)*DATA_W +: DATA_W];
      end
      R_IO_IN: begin
        if (we_q) begin
          acc_err_d = 1'b1;
        end else begin
          rd_val_d = io_in_d[int'(dec_d.chan)*DATA_W +: DATA_W];
        end
      end
      default: begin
        acc_err_d = 1'b1;
      end
    endcase
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (exec_d && we_q && (dec_d.region == R_RAM)) begin
      ram_q[addr_q[RAM_AW-1:0]] <= wdata_q;
    end
  end

  // Access FSM with registered handshake, result, MDR and output registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      we_q      <= 1'b0;
      mdrw_q    <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      mem_out_q <= {DATA_W{1'b0}};
      mdr_q     <= {DATA_W{1'b0}};
      dp_out_q  <= {IO_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (req) begin
            we_q    <= we;
            mdrw_q  <= mdrw;
            addr_q  <= addr_in;
            wdata_q <= dataw_in;
            cnt_q   <= CNT_W'(WAIT_STATES);
            busy_q  <= 1'b1;
            state_q <= S_ACCESS;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ACCESS: begin
          if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= acc_err_d;
            state_q <= S_RESP;
            if (acc_err_d) begin
              mem_out_q <= {DATA_W{1'b0}};
            end else if (we_q) begin
              mem_out_q <= wdata_q;
              if (dec_d.region == R_IO_OUT) begin
                dp_out_q[int'(dec_d.chan)*DATA_W +: DATA_W] <= wdata_q;
              end
            end else begin
              mem_out_q <= rd_val_d;
              if (mdrw_q) begin
                mdr_q <= rd_val_d;
              end
            end
          end
        end
        S_RESP: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (req) begin
            we_q    <= we;
            mdrw_q  <= mdrw;
            addr_q  <= addr_in;
            wdata_q <= dataw_in;
            cnt_q   <= CNT_W'(WAIT_STATES);
            busy_q  <= 1'b1;
            state_q <= S_ACCESS;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign mem_out = mem_out_q;
  assign mdr_out = mdr_q;
  assign dp_out  = dp_out_q;

endmodule

// File: tb/tb_mem_stage_mmio.sv
// tb_mem_stage_mmio: directed plus randomized accesses against an
// address-map level reference model (RAM array, output registers, MDR).
module tb_mem_stage_mmio;

  localparam int WS = 1;

  logic        CLK = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic        mdrw;
  logic [15:0] addr_in;
  logic [15:0] dataw_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] mem_out;
  logic [15:0] mdr_out;
  logic [31:0] dp_input;
  logic [31:0] dp_out;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] m_ram [1024];
  logic [15:0] m_out [2];
  logic [15:0] m_mdr;

  mem_stage_mmio #(
    .DATA_W(16), .ADDR_W(16), .MEM_DEPTH(1024), .NUM_IO(2),
    .IO_BASE('h3FF0), .WAIT_STATES(WS)
  ) dut (
    .CLK(CLK), .reset(reset), .req(req), .we(we), .mdrw(mdrw),
    .addr_in(addr_in), .dataw_in(dataw_in), .busy(busy), .done(done),
    .err(err), .mem_out(mem_out), .mdr_out(mdr_out),
    .dp_input(dp_input), .dp_out(dp_out)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access with a single-cycle req; model computed from the address map.
  task automatic do_access(input logic w, input logic m, input logic [15:0] a, input logic [15:0] d);
    logic        exp_err;
    logic [15:0] val;
    logic [15:0] exp_mem;
    logic [31:0] old_dp;
    int          ch;
    int          busy_n;
    bit          seen;
    exp_err = 1'b0;
    val     = 16'h0000;
    ch      = -1;
    if (a < 16'd1024) begin
      val = m_ram[a[9:0]];
    end else if (a >= 16'h3FF0 && a < 16'h3FF4) begin
      ch = int'(a - 16'h3FF0) / 2;
      if ((int'(a - 16'h3FF0) % 2) == 1) begin
        if (w) exp_err = 1'b1;
        else   val = dp_input[ch*16 +: 16];
      end else begin
        val = m_out[ch];
      end
    end else begin
      exp_err = 1'b1;
    end
    old_dp = {m_out[1], m_out[0]};

    @(negedge CLK);
    req = 1'b1; we = w; mdrw = m; addr_in = a; dataw_in = d;
    @(negedge CLK);
    req = 1'b0;
    check_val("dp_before_exec", dp_out, old_dp);
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (busy) busy_n++;
      if (done) seen = 1'b1;
      else @(negedge CLK);
    end
    check_val("done_seen", 32'(seen), 32'd1);

    if (exp_err) begin
      exp_mem = 16'h0000;
    end else if (w) begin
      exp_mem = d;
      if (a < 16'd1024) m_ram[a[9:0]] = d;
      else m_out[ch] = d;
    end else begin
      exp_mem = val;
      if (m) m_mdr = val;
    end
    check_val("busy_cycles", 32'(busy_n), 32'(WS + 1));
    check_val("err", 32'(err), 32'(exp_err));
    check_val("mem_out", 32'(mem_out), 32'(exp_mem));
    check_val("mdr_out", 32'(mdr_out), 32'(m_mdr));
    check_val("dp_out", dp_out, {m_out[1], m_out[0]});
    @(negedge CLK);
    check_val("done_one_cycle", 32'(done), 32'd0);
    check_val("mem_out_held", 32'(mem_out), 32'(exp_mem));
  endtask

  initial begin
    int ndone;
    int last;
    int extra;
    logic [15:0] a;
    reset = 1'b1; req = 1'b0; we = 1'b0; mdrw = 1'b0;
    addr_in = 16'h0000; dataw_in = 16'h0000; dp_input = 32'h0;
    m_mdr = 16'h0000; m_out[0] = 16'h0000; m_out[1] = 16'h0000;
    for (int i = 0; i < 1024; i++) m_ram[i] = 16'h0000;
    #3;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_outs", {dp_out}, 32'h0);
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    check_val("post_rst_busy", 32'(busy), 32'd0);

    // Known contents for the RAM words the random phase uses.
    for (int i = 0; i < 16; i++) do_access(1'b1, 1'b0, 16'(i), 16'($urandom));

    // RAM write/read.
    do_access(1'b1, 1'b0, 16'h0001, 16'h1337);
    do_access(1'b0, 1'b1, 16'h0001, 16'h0000);
    check_val("mdr_1337", 32'(mdr_out), 32'h1337);

    // MMIO output and input.
    do_access(1'b1, 1'b0, 16'h3FF2, 16'hDEAD);
    check_val("dp_hi_dead", 32'(dp_out[31:16]), 32'hDEAD);
    do_access(1'b0, 1'b0, 16'h3FF2, 16'h0000);
    dp_input[15:0] = 16'h0001;
    repeat (3) @(negedge CLK);
    do_access(1'b0, 1'b1, 16'h3FF1, 16'h0000);
    check_val("in_0001", 32'(mem_out), 32'h0001);

    // Error cases.
    do_access(1'b1, 1'b0, 16'h2000, 16'h5555);
    do_access(1'b0, 1'b0, 16'h0000, 16'h0000);
    do_access(1'b1, 1'b0, 16'h3FF1, 16'hAAAA);

    // Asynchronous reset mid-cycle clears every output immediately.
    @(negedge CLK);
    #2 reset = 1'b1;
    #1;
    check_val("async_rst_dp", dp_out, 32'h0);
    check_val("async_rst_mdr", 32'(mdr_out), 32'h0);
    check_val("async_rst_mem", 32'(mem_out), 32'h0);
    m_out[0] = 16'h0000; m_out[1] = 16'h0000; m_mdr = 16'h0000;
    @(negedge CLK);
    reset = 1'b0;

    // Reset during ACCESS drops the pending write.
    do_access(1'b1, 1'b0, 16'h0002, 16'h1111);
    @(negedge CLK);
    req = 1'b1; we = 1'b1; mdrw = 1'b0; addr_in = 16'h0002; dataw_in = 16'hBEEF;
    @(negedge CLK);
    req = 1'b0;
    check_val("mid_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    m_out[0] = 16'h0000; m_out[1] = 16'h0000; m_mdr = 16'h0000;
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (done) extra++;
    end
    check_val("mid_rst_no_done", 32'(extra), 32'd0);
    do_access(1'b0, 1'b0, 16'h0002, 16'h0000);
    check_val("mid_rst_kept", 32'(mem_out), 32'h1111);

    // Back-to-back reads with req held high.
    @(negedge CLK);
    req = 1'b1; we = 1'b0; mdrw = 1'b1; addr_in = 16'h0000;
    ndone = 0;
    last  = -1;
    for (int c = 0; c < 40 && ndone < 4; c++) begin
      @(negedge CLK);
      if (done) begin
        check_val("b2b_data", 32'(mem_out), 32'(m_ram[ndone]));
        if (ndone > 0) check_val("b2b_interval", 32'(c - last), 32'(WS + 2));
        last = c;
        ndone++;
        if (ndone < 4) addr_in = 16'(ndone);
        else req = 1'b0;
      end
    end
    m_mdr = m_ram[3];
    check_val("b2b_count", 32'(ndone), 32'd4);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (done || busy) extra++;
    end
    check_val("b2b_no_extra", 32'(extra), 32'd0);
    check_val("b2b_mdr", 32'(mdr_out), 32'(m_mdr));

    // Randomized accesses across RAM, I/O window and unmapped space.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0, 3: a = 16'($urandom_range(0, 15));
        1:    a = 16'h3FF0 + 16'($urandom_range(0, 3));
        default: begin
          case ($urandom_range(0, 3))
            0:       a = 16'h2000;
            1:       a = 16'h0400;
            2:       a = 16'h3FF4;
            default: a = 16'hFFFF;
          endcase
        end
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(negedge CLK);
        dp_input = $urandom;
        repeat (2) @(negedge CLK);
      end
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_mmio.md
# mem_stage_mmio

Parametrised memory-access stage for the multicycle datapath: word-addressed data RAM, memory data register (MDR), and a memory-mapped I/O window of `NUM_IO` input/output channel pairs. Each access takes a configurable number of wait states and uses a req/busy/done handshake. The block sits between the ALU/address stage and writeback, and replaces the fixed 16-bit, single-I/O, single-cycle memory stage.

## Interface
- `DATA_W`, 16, word width.
- `ADDR_W`, 16, address width; addresses are word addresses.
- `MEM_DEPTH`, 1024, RAM words, mapped at addresses 0 .. `MEM_DEPTH`-1.
- `NUM_IO`, 2, I/O channel count.
- `IO_BASE`, 'h3FF0, base of the I/O window. Must satisfy `IO_BASE` >= `MEM_DEPTH`.
- `WAIT_STATES`, 1, extra cycles per access (0..15).

- `CLK`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  access request; sampled when the stage is not busy.
- `we`  in  1  1 = write, 0 = read; captured with `req`.
- `mdrw`  in  1  load the MDR on completion of a read; captured with `req`.
- `addr_in`  in  `ADDR_W`  access address; captured with `req`.
- `dataw_in`  in  `DATA_W`  write data; captured with `req`.
- `busy`  out  1  high while state is ACCESS.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`: access was unmapped or illegal.
- `mem_out`  out  `DATA_W`  result of the last completed access; held until the next completion.
- `mdr_out`  out  `DATA_W`  MDR contents.
- `dp_input`  in  `NUM_IO`*`DATA_W`  external inputs; channel i occupies bits [i*`DATA_W` +: `DATA_W`].
- `dp_out`  out  `NUM_IO`*`DATA_W`  output registers, packed the same way as `dp_input`.

## Operation
- Address map:
  - RAM: addresses < `MEM_DEPTH`.
  - Output register of channel i: `IO_BASE`+2i (read/write).
  - Input of channel i: `IO_BASE`+2i+1 (read-only).
  - Every other address is unmapped.
- FSM states:
  - IDLE: on `req`, capture `we`/`mdrw`/`addr_in`/`dataw_in`, load cnt=`WAIT_STATES`, go to ACCESS.
  - ACCESS: if cnt≠0, decrement. If cnt=0, execute the access and go to RESP.
  - RESP: `done`=1. On `req`, capture and go to ACCESS (back-to-back). Otherwise go to IDLE.
- Execution edge, write:
  - RAM or output-register target is updated.
  - `mem_out`=written data.
  - MDR is unchanged.
- Execution edge, read:
  - `mem_out` = RAM word, output register, or input value.
  - MDR loads the same value if `mdrw`.
- Unmapped access, or a write to an input address:
  - No state change except `mem_out`=0.
  - `err`=1 during RESP.
- RAW hazard: a read issued after a write to the same address returns the new data. RAM is read at the execution edge, not at capture.
- `req` during ACCESS is ignored; the master must hold it or retry.
- Reset (asynchronous, at any time, including mid-ACCESS):
  - FSM goes to IDLE and the pending access is dropped; no RAM or I/O write occurs.
  - `busy`, `done`, `err`, `mem_out`, `mdr_out`, `dp_out` all reset to 0.
  - RAM contents are not reset.

## Timing
- `req` is sampled at edge k. The execution edge is k+1+`WAIT_STATES`. `done` is high for the cycle after that edge.
- `busy` is high for `WAIT_STATES`+1 cycles per access.
- Sustained throughput with `req` held high: one access every `WAIT_STATES`+2 cycles.
- `dp_out` changes at the execution edge of the write.
- `mem_out`/`mdr_out` are valid when `done`=1 and are held afterwards.
- Input read latency: the value sampled at the execution edge. With the synchronizer enabled, this is the `dp_input` value from 2 edges earlier.

## Configuration
- `MEM_STAGE_IO_SYNC_EN` defined:
  - Each `dp_input` channel passes through a 2-flop synchronizer, reset to 0.
  - Input reads see data delayed by 2 cycles.
- `MEM_STAGE_IO_SYNC_EN` undefined: `dp_input` is sampled directly at the execution edge.

## Structure
- Package `mem_stage_pkg` holds:
  - FSM state enum (IDLE, ACCESS, RESP).
  - Region enum (RAM, IO_OUT, IO_IN, UNMAPPED) and the `decode_addr` function that returns region plus channel index.
  - Wait-counter width constant (4).
- One sub-module, `mem_stage_sync`: a parametrised-width 2-flop synchronizer, instantiated per channel under the macro.
- RAM is an inferred array in the top module.

## Test plan
All scenarios use default parameters and `WAIT_STATES`=1.
1. Reset: assert `reset` asynchronously mid-cycle → all outputs 0 immediately. `busy`=0 after release.
2. RAM write/read:
   - Write addr 'h0001, data 'h1337, one-cycle `req` → `busy` high 2 cycles, then `done` pulse with `mem_out`='h1337.
   - Then read 'h0001 with `mdrw`=1 → `mem_out`=`mdr_out`='h1337.
3. MMIO:
   - Write 'h3FF2, data 'hDEAD → `dp_out`[31:16]='hDEAD at the execution edge, and a read of 'h3FF2 returns 'hDEAD.
   - Set `dp_input`[15:0]='h0001, then read 'h3FF1 → 'h0001 (hold the input ≥2 cycles when synchronized).
4. Errors:
   - Write 'h2000 → `err`=1 with `done`, `mem_out`=0, and a later read of 'h0000 is unchanged.
   - Write 'h3FF1 → `err`=1 and `dp_out` unchanged.
5. Mid-operation reset: write 'h0002 data 'hBEEF, assert `reset` during ACCESS → 'h0002 keeps its prior value and no `done` pulse appears.
6. Back-to-back: hold `req`=1 for 4 reads → `done` pulses every 3 cycles, and `req` during ACCESS is not double-captured.
